uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 31 +++
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial-receive handshake bundle: line input, consumer acknowledge and
// the received-byte/status outputs.
interface uart_rx_if;
    logic       rx;
    logic       read;
    logic [7:0] data_out;
    logic       data_ready;
    logic       receiving;
    logic       frame_err;
    logic       overrun;

    modport slave (
        input  rx,
        input  read,
        output data_out,
        output data_ready,
        output receiving,
        output frame_err,
        output overrun
    );

    modport master (
        output rx,
        output read,
        input  data_out,
        input  data_ready,
        input  receiving,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a half-period start qualification,
// single-entry holding register with overrun and framing-error reporting.
module uart_rx #(
    parameter int CLOCK_RATE   = 25175000,
    parameter int BAUD_RATE    = 9600,
    parameter int COUNTER_SIZE = 12
) (
    input logic     clk,
    input logic     rst_n,
    uart_rx_if.slave bus
);

    localparam int COUNTER_MAX_I = CLOCK_RATE / BAUD_RATE - 1;
    localparam logic [COUNTER_SIZE-1:0] COUNTER_MAX = COUNTER_SIZE'(COUNTER_MAX_I);
    localparam logic [COUNTER_SIZE-1:0] HALF_MAX    = COUNTER_SIZE'(COUNTER_MAX_I / 2);
    localparam logic [COUNTER_SIZE-1:0] COUNTER_ONE = COUNTER_SIZE'(1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic [2:0]              state;
    logic [COUNTER_SIZE-1:0] counter;
    logic [2:0]              bit_count;
    logic [7:0]              shift_reg;
    logic                    rx_meta;
    logic                    rx_sync;
    logic [7:0]              data_out_q;
    logic                    data_ready_q;
    logic                    receiving_q;
    logic                    frame_err_q;
    logic                    overrun_q;
    logic                    complete;

    assign bus.data_out   = data_out_q;
    assign bus.data_ready = data_ready_q;
    assign bus.receiving  = receiving_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;

    // Good stop bit sampled this cycle.
    assign complete = (state == STOP) && (counter == COUNTER_MAX) && rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            counter     <= '0;
            bit_count   <= '0;
            shift_reg   <= '0;
            data_out_q  <= '0;
            receiving_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state       <= START;
                        counter     <= '0;
                        receiving_q <= 1'b1;
                    end
                end
                START: begin
                    if (counter == HALF_MAX) begin
                        counter <= '0;
                        if (!rx_sync) begin
                            state     <= DATA;
                            bit_count <= '0;
                        end else begin
                            state       <= IDLE;
                            receiving_q <= 1'b0;
                        end
                    end else begin
                        counter <= counter + COUNTER_ONE;
                    end
                end
                DATA: begin
                    if (counter == COUNTER_MAX) begin
                        counter   <= '0;
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        bit_count <= bit_count + 3'd1;
                        if (bit_count == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        counter <= counter + COUNTER_ONE;
                    end
                end
                STOP: begin
                    if (counter == COUNTER_MAX) begin
                        counter <= '0;
                        if (rx_sync) begin
                            data_out_q  <= shift_reg;
                            receiving_q <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        counter <= counter + COUNTER_ONE;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line is a break, not a new start bit.
                    if (rx_sync) begin
                        state       <= IDLE;
                        receiving_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    counter     <= '0;
                    receiving_q <= 1'b0;
                end
            endcase
        end
    end

    // A read coinciding with completion consumes the old byte, so no overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (complete) begin
            data_ready_q <= 1'b1;
            overrun_q    <= bus.read ? 1'b0 : (overrun_q | data_ready_q);
        end else if (bus.read) begin
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit (CounterMax=15, HalfMax=7).
module tb_uart_rx;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   fe_cnt;
    int   fall_cyc;
    int   frame_start;
    int   fe_before;
    logic prev_recv;

    uart_rx_if bus ();

    uart_rx #(
        .CLOCK_RATE  (160),
        .BAUD_RATE   (10),
        .COUNTER_SIZE(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock, then sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.frame_err === 1'b1) fe_cnt++;
        if (prev_recv && bus.receiving === 1'b0) fall_cyc = cyc;
        prev_recv = (bus.receiving === 1'b1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive ncyc clocks of an 8N1 frame; read is high on edge number rd_at.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input int rd_at, input int ncyc);
        int   idx;
        logic val;
        frame_start = cyc;
        fall_cyc    = -1;
        for (int k = 1; k <= ncyc; k++) begin
            idx = (k - 1) / 16;
            if (idx == 0)      val = 1'b0;
            else if (idx <= 8) val = b[idx-1];
            else               val = stop_val;
            bus.rx   = val;
            bus.read = (k == rd_at);
            tick();
        end
        bus.read = 1'b0;
    endtask

    task automatic read_pulse();
        bus.read = 1'b1;
        tick();
        bus.read = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        fe_cnt    = 0;
        fall_cyc  = -1;
        prev_recv = 1'b0;
        bus.rx    = 1'b1;
        bus.read  = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        check("rst_data_out",   32'(bus.data_out),   32'h00);
        check("rst_data_ready", 32'(bus.data_ready), 32'h0);
        check("rst_receiving",  32'(bus.receiving),  32'h0);
        check("rst_frame_err",  32'(bus.frame_err),  32'h0);
        check("rst_overrun",    32'(bus.overrun),    32'h0);
        ticks(3);
        rst_n = 1'b1;
        ticks(5);

        // 0xA5: completion 155 edges after the start bit begins
        fe_before = fe_cnt;
        send_frame(8'hA5, 1'b1, 0, 160);
        check("a5_data_out",   32'(bus.data_out),   32'hA5);
        check("a5_data_ready", 32'(bus.data_ready), 32'h1);
        check("a5_receiving",  32'(bus.receiving),  32'h0);
        check("a5_done_cycle", 32'(fall_cyc - frame_start), 32'd155);
        check("a5_no_fe",      32'(fe_cnt - fe_before), 32'd0);
        read_pulse();
        check("a5_read_clr",   32'(bus.data_ready), 32'h0);

        // short low glitch: START rejects at HalfMax
        frame_start = cyc;
        fall_cyc    = -1;
        bus.rx = 1'b0;
        ticks(4);
        bus.rx = 1'b1;
        ticks(20);
        check("glitch_abort_cycle", 32'(fall_cyc - frame_start), 32'd11);
        check("glitch_receiving",   32'(bus.receiving),  32'h0);
        check("glitch_data_ready",  32'(bus.data_ready), 32'h0);
        check("glitch_no_fe",       32'(fe_cnt - fe_before), 32'd0);
        send_frame(8'h3C, 1'b1, 0, 160);
        check("3c_data_out",   32'(bus.data_out),   32'h3C);
        check("3c_data_ready", 32'(bus.data_ready), 32'h1);
        check("3c_done_cycle", 32'(fall_cyc - frame_start), 32'd155);
        read_pulse();

        // bad stop bit followed by a long break
        fe_before = fe_cnt;
        send_frame(8'h55, 1'b0, 0, 160);
        bus.rx = 1'b0;
        ticks(640);
        check("fe_pulse_count", 32'(fe_cnt - fe_before), 32'd1);
        check("fe_data_out",    32'(bus.data_out),   32'h3C);
        check("fe_data_ready",  32'(bus.data_ready), 32'h0);
        check("fe_wait_recv",   32'(bus.receiving),  32'h1);
        bus.rx = 1'b1;
        ticks(5);
        check("fe_release_recv", 32'(bus.receiving), 32'h0);
        ticks(30);
        check("fe_idle_recv",  32'(bus.receiving),  32'h0);
        check("fe_idle_ready", 32'(bus.data_ready), 32'h0);

        // two bytes without read -> overrun
        send_frame(8'h11, 1'b1, 0, 160);
        check("11_data_out", 32'(bus.data_out), 32'h11);
        check("11_overrun",  32'(bus.overrun),  32'h0);
        send_frame(8'h22, 1'b1, 0, 160);
        check("22_data_out",   32'(bus.data_out),   32'h22);
        check("22_data_ready", 32'(bus.data_ready), 32'h1);
        check("22_overrun",    32'(bus.overrun),    32'h1);
        read_pulse();
        check("ovr_read_ready",   32'(bus.data_ready), 32'h0);
        check("ovr_read_overrun", 32'(bus.overrun),    32'h0);
        check("ovr_read_data",    32'(bus.data_out),   32'h22);

        // read on the exact completion edge of the second byte
        send_frame(8'h66, 1'b1, 0, 160);
        check("66_data_ready", 32'(bus.data_ready), 32'h1);
        send_frame(8'h77, 1'b1, 155, 160);
        check("77_data_out",   32'(bus.data_out),   32'h77);
        check("77_data_ready", 32'(bus.data_ready), 32'h1);
        check("77_overrun",    32'(bus.overrun),    32'h0);

        // reset in the middle of data bit 4
        fe_before = fe_cnt;
        send_frame(8'h99, 1'b1, 0, 88);
        check("mid_receiving", 32'(bus.receiving), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data_out",   32'(bus.data_out),   32'h00);
        check("mid_rst_data_ready", 32'(bus.data_ready), 32'h0);
        check("mid_rst_receiving",  32'(bus.receiving),  32'h0);
        check("mid_rst_frame_err",  32'(bus.frame_err),  32'h0);
        check("mid_rst_overrun",    32'(bus.overrun),    32'h0);
        bus.rx = 1'b1;
        ticks(3);
        rst_n = 1'b1;
        ticks(200);
        check("post_rst_ready", 32'(bus.data_ready), 32'h0);
        check("post_rst_no_fe", 32'(fe_cnt - fe_before), 32'd0);
        send_frame(8'h0F, 1'b1, 0, 160);
        check("0f_data_out",   32'(bus.data_out),   32'h0F);
        check("0f_data_ready", 32'(bus.data_ready), 32'h1);
        check("0f_done_cycle", 32'(fall_cyc - frame_start), 32'd155);
        check("0f_overrun",    32'(bus.overrun),    32'h0);
        ticks(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
